cdb_result_buffer: RTL

- Per-functional-unit output queue on the requester side of the CDB arbiter handshake.
- Accepts completed results (value + ROB tag) from an execution unit (ALU or branch) and holds them in order.
- Raises a bus request while any entry is held; retires the head entry on each cycle the arbiter grants the bus.
- Decouples execution-unit completion from CDB contention, so a unit that loses arbitration does not stall its pipeline until the queue fills.

---
 rtl/cdb_pkg.sv | 10 +
 rtl/cdb_result_buffer.sv | 53 +++++
 2 files changed

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared CDB entry type and default sizes for the arbiter, bus interface and result buffers
package cdb_pkg;
    localparam int CDB_WIDTH = 31;
    localparam int CDB_ROB = 2;
    localparam int CDB_DEPTH = 4;
    typedef struct packed {
        logic [CDB_WIDTH:0] result;
        logic [CDB_ROB:0] rob;
    } cdb_entry_t;
endpackage

// File: rtl/cdb_result_buffer.sv
// cdb_result_buffer: in-order result queue between an execution unit and the CDB arbiter
module cdb_result_buffer
    import cdb_pkg::*;
#(
    parameter int WIDTH = CDB_WIDTH,
    parameter int ROB = CDB_ROB,
    parameter int DEPTH = CDB_DEPTH,
    parameter int PTR = $clog2(DEPTH) - 1
) (
    input  logic           clk,
    input  logic           clear,
    input  logic           flush,
    input  logic           fuValid,
    input  logic [WIDTH:0] fuResult,
    input  logic [ROB:0]   fuRob,
    output logic           fuReady,
    output logic           cdbRequest,
    output logic [WIDTH:0] cdbResult,
    output logic [ROB:0]   cdbRob,
    input  logic           cdbGrant,
    output logic [PTR+1:0] occupancy
);
    logic [WIDTH:0] res_mem [DEPTH];
    logic [ROB:0] rob_mem [DEPTH];
    logic [PTR:0] wr_ptr, rd_ptr;
    logic [PTR+1:0] count;
    logic push, pop;
    assign cdbRequest = count != '0;
    assign fuReady = count < (PTR+2)'(DEPTH);
    assign occupancy = count;
    assign push = fuValid && fuReady;
    assign pop = cdbRequest && cdbGrant;
    assign cdbResult = cdbRequest ? res_mem[rd_ptr] : '0;
    assign cdbRob = cdbRequest ? rob_mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (clear || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR+2)'(push) - (PTR+2)'(pop);
        end
    end
    // storage needs no reset; emptiness is tracked by count alone
    always_ff @(posedge clk) begin
        if (push && !clear && !flush) begin
            res_mem[wr_ptr] <= fuResult;
            rob_mem[wr_ptr] <= fuRob;
        end
    end
endmodule
